// File: rtl/wallace_mac_accum.sv
// Frame accumulator behind the 3-stage Wallace multiplier: sums FRAME_LEN signed products
// and hands each frame sum out on a valid/ready register. Define WALLACE_ACC_SAT_EN to saturate instead of wrap.
module wallace_mac_accum #(
    parameter  int FRAME_LEN = 4,
    parameter  int ACC_W     = 72,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [64:0]        product,
    input  logic               clear,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               overflow
);

    localparam int               EXT_W    = ACC_W + 1 - 65;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
    localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM, STALL} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   sum_val;
    logic               sum_ovf;
    logic               accept;
    logic               frame_done;
    logic               out_free;

    // One guard bit above the accumulator exposes signed overflow as a top-two-bit mismatch.
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {{EXT_W{product[64]}}, product};
        sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef WALLACE_ACC_SAT_EN
        if (sum_ovf)
            sum_val = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
        else
            sum_val = sum_ext[ACC_W-1:0];
`else
        sum_val = sum_ext[ACC_W-1:0];
`endif
    end

    assign accept     = in_valid & in_ready;
    assign frame_done = accept & ~clear & (frame_cnt == LAST_CNT);
    assign out_free   = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ACCUM;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (frame_done && !out_free) state_d = STALL;
            STALL: if (out_ready)               state_d = ACCUM;
            default:                            state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ACCUM);
    end

    // In STALL the finished frame waits in acc until the output register frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            frame_cnt <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (state_q == STALL) begin
            if (out_ready) begin
                acc_out   <= acc;
                acc       <= '0;
                frame_cnt <= '0;
            end
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (clear) begin
                acc       <= '0;
                frame_cnt <= '0;
            end else if (accept) begin
                if (sum_ovf)
                    overflow <= 1'b1;
                if (frame_done) begin
                    if (out_free) begin
                        acc_out   <= sum_val;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        frame_cnt <= '0;
                    end else begin
                        acc       <= sum_val;
                        frame_cnt <= FULL_CNT;
                    end
                end else begin
                    acc       <= sum_val;
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac_accum.sv
// Scoreboard bench for wallace_mac_accum: directed frames push expected sums, monitors pop on each output handshake.
// A 66-bit second instance exercises the overflow boundary (saturating when WALLACE_ACC_SAT_EN is defined).
module tb_wallace_mac_accum;

    logic        clk;
    logic        rst;
    logic        in_valid, clear, out_ready;
    logic [64:0] product;
    logic        in_ready, out_valid, overflow;
    logic [71:0] acc_out;
    logic [2:0]  frame_cnt;

    logic        in_valid2, clear2, out_ready2;
    logic [64:0] product2;
    logic        in_ready2, out_valid2, overflow2;
    logic [65:0] acc_out2;
    logic [2:0]  frame_cnt2;

    logic [71:0] exp_q[$];
    logic [65:0] exp_q2[$];
    int          n_cmp = 0;
    int          n_err = 0;

    wallace_mac_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .product(product), .clear(clear),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    wallace_mac_accum #(.FRAME_LEN(4), .ACC_W(66)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .product(product2), .clear(clear2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
        .acc_out(acc_out2), .frame_cnt(frame_cnt2), .overflow(overflow2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [64:0] p, input logic c);
        in_valid = v;
        product  = p;
        clear    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Outputs are sampled on the falling edge, where a valid&ready pair means a transfer at the next rise.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL scoreboard: unexpected acc_out 0x%0h, expected none", acc_out);
            end else begin
                checkOutput("acc_out", acc_out, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (exp_q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL scoreboard2: unexpected acc_out 0x%0h, expected none", acc_out2);
            end else begin
                checkOutput("acc_out_w66", {6'b0, acc_out2}, {6'b0, exp_q2.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0]        r;
        logic signed [71:0] model;
        int                 n_in_frame, frames, cyc;

        rst = 1'b1;
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; product = '0;
        in_valid2 = 1'b0; clear2 = 1'b0; out_ready2 = 1'b1; product2 = '0;
        #12;
        checkOutput("rst_frame_cnt", 72'(frame_cnt), 72'd0);
        checkOutput("rst_out_valid", 72'(out_valid), 72'd0);
        checkOutput("rst_in_ready", 72'(in_ready), 72'd1);
        checkOutput("rst_acc_out", acc_out, 72'd0);
        checkOutput("rst_overflow", 72'(overflow), 72'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame: 3+5-2+10 = 16, valid for exactly one cycle.
        out_ready = 1'b1;
        exp_q.push_back(72'd16);
        applyStimulus(1'b1, 65'd3, 1'b0);
        applyStimulus(1'b1, 65'd5, 1'b0);
        applyStimulus(1'b1, -65'sd2, 1'b0);
        applyStimulus(1'b1, 65'd10, 1'b0);
        checkOutput("frame_out_valid", 72'(out_valid), 72'd1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("frame_valid_drop", 72'(out_valid), 72'd0);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, 65'd1, 1'b0);
        applyStimulus(1'b1, 65'd2, 1'b0);
        checkOutput("mid_frame_cnt", 72'(frame_cnt), 72'd2);
        rst = 1'b1;
        #2;
        checkOutput("midrst_frame_cnt", 72'(frame_cnt), 72'd0);
        checkOutput("midrst_acc_out", acc_out, 72'd0);
        checkOutput("midrst_out_valid", 72'(out_valid), 72'd0);
        checkOutput("midrst_in_ready", 72'(in_ready), 72'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two frames of ones with the consumer stalled: second frame parks in STALL.
        out_ready = 1'b0;
        exp_q.push_back(72'd4);
        exp_q.push_back(72'd4);
        repeat (8) applyStimulus(1'b1, 65'd1, 1'b0);
        checkOutput("stall_in_ready", 72'(in_ready), 72'd0);
        checkOutput("stall_frame_cnt", 72'(frame_cnt), 72'd4);
        applyStimulus(1'b1, 65'd100, 1'b0);
        out_ready = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("unstall_in_ready", 72'(in_ready), 72'd1);
        checkOutput("unstall_frame_cnt", 72'(frame_cnt), 72'd0);
        checkOutput("unstall_out_valid", 72'(out_valid), 72'd1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drained_out_valid", 72'(out_valid), 72'd0);

        // Clear with a pending output: the pending sum is untouched, the cleared partial is lost.
        out_ready = 1'b0;
        exp_q.push_back(72'd4);
        repeat (4) applyStimulus(1'b1, 65'd1, 1'b0);
        applyStimulus(1'b1, 65'd9, 1'b0);
        applyStimulus(1'b1, 65'd9, 1'b0);
        applyStimulus(1'b1, 65'd50, 1'b1);
        checkOutput("clear_frame_cnt", 72'(frame_cnt), 72'd0);
        checkOutput("clear_out_valid", 72'(out_valid), 72'd1);
        checkOutput("clear_acc_out", acc_out, 72'd4);
        out_ready = 1'b1;
        exp_q.push_back(72'd28);
        repeat (4) applyStimulus(1'b1, 65'd7, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);

        // Narrow instance: four products of 2^64-1 leave the 66-bit signed range on the third.
`ifdef WALLACE_ACC_SAT_EN
        exp_q2.push_back(66'h1_FFFF_FFFF_FFFF_FFFF);
`else
        exp_q2.push_back(66'h3_FFFF_FFFF_FFFF_FFFC);
`endif
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            product2  = 65'h0_FFFF_FFFF_FFFF_FFFF;
            @(posedge clk);
            #1;
            if (i == 1)
                checkOutput("w66_no_overflow_yet", 72'(overflow2), 72'd0);
        end
        in_valid2 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w66_overflow", 72'(overflow2), 72'd1);
        checkOutput("w72_overflow_clear", 72'(overflow), 72'd0);

        // Random products, 50% enable gated by in_ready, random consumer backpressure.
        model = '0;
        n_in_frame = 0;
        frames = 0;
        cyc = 0;
        while (frames < 30 && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1 && in_ready) begin
                r = $urandom;
                model = model + {{40{r[31]}}, r};
                n_in_frame++;
                if (n_in_frame == 4) begin
                    exp_q.push_back(model);
                    model = '0;
                    n_in_frame = 0;
                    frames++;
                end
                applyStimulus(1'b1, {{33{r[31]}}, r}, 1'b0);
            end else begin
                applyStimulus(1'b0, '0, 1'b0);
            end
            cyc++;
        end
        checkOutput("random_frames_issued", 72'(frames), 72'd30);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++)
            applyStimulus(1'b0, '0, 1'b0);
        checkOutput("scoreboard_empty", 72'(exp_q.size()), 72'd0);
        checkOutput("scoreboard2_empty", 72'(exp_q2.size()), 72'd0);
        checkOutput("final_overflow", 72'(overflow), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
